voice_mux_scanner: RTL and testbench
====================================

# voice_mux_scanner

Sequencer that drives the select input of the 16-bit 16-to-1 voice mux and paces samples into the shared DAC. It scans only the enabled voice channels in ascending order with wrap-around, waits a programmable settle time after each select change, then handshakes with the DAC and issues a one-cycle load strobe. It sits between the voice-enable control registers and the mux/DAC pair in the synth datapath.

## Interface
- SETTLE_CYCLES, 4, cycles the mux output is allowed to settle after o_select changes; legal range 1..255
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  run scanning; low stops after the current load completes
- i_channel_mask  in  16  bit n high = channel n included in scan
- i_dac_ready  in  1  DAC can accept a sample this cycle
- o_select  out  4  drives mux i_select
- o_dac_load  out  1  one-cycle strobe: mux output valid for channel o_select, DAC captures it
- o_frame_start  out  1  high with o_dac_load on the first channel of each scan pass
- o_busy  out  1  high in every state except IDLE

## Operation
- Reset: state IDLE, o_select=0, o_dac_load=0, o_frame_start=0, o_busy=0, restart flag set, settle counter 0.
- States: IDLE, SEEK, SETTLE, WAIT_READY, LOAD.
- IDLE: if i_enable and i_channel_mask!=0 -> SEEK; otherwise stay. Entering IDLE sets restart flag.
- SEEK (1 cycle): search i_channel_mask for the next set bit. Restart flag set: search from channel 0 inclusive. Otherwise search from o_select+1 upward, wrapping 15->0, with o_select itself examined last. Load result into o_select. Set frame flag if restart flag set or result <= previous o_select (wrap). Clear restart flag. Load settle counter = SETTLE_CYCLES-1. -> SETTLE. If mask is 0 in this cycle -> IDLE, o_select unchanged.
- SETTLE: decrement counter; at 0 -> WAIT_READY.
- WAIT_READY: if i_dac_ready -> LOAD; otherwise hold indefinitely.
- LOAD (1 cycle): o_dac_load=1, o_frame_start=frame flag; clear frame flag. Next state: SEEK if i_enable and mask!=0, else IDLE.
- Abort: in SETTLE or WAIT_READY, if i_channel_mask[o_select] goes low -> SEEK (no load for that channel, frame flag retained); if entire mask is 0 -> IDLE.
- i_enable low in SETTLE/WAIT_READY does not abort; the current sample completes, then IDLE.
- Single enabled channel: it is reloaded every pass and every load carries o_frame_start.
- o_select changes only on exit from SEEK; it is stable from SEEK exit through LOAD.
- Reset asserted in any state returns to reset values the next edge; no strobe is issued that cycle.

## Timing
- All outputs registered; o_dac_load and o_frame_start are single-cycle pulses.
- Per-channel period with i_dac_ready held high: 1 (SEEK) + SETTLE_CYCLES + 1 (WAIT_READY) + 1 (LOAD) = SETTLE_CYCLES+3 cycles. Default: 7.
- Full 16-channel frame at default: 112 cycles; k enabled channels: 7k cycles.
- First load after i_enable rises in IDLE: SETTLE_CYCLES+4 cycles later (one IDLE decision cycle).
- i_dac_ready low stretches WAIT_READY one cycle per low cycle; the load fires the cycle after ready is sampled high.
- Mask changes take effect at the next SEEK, or at the abort check in SETTLE/WAIT_READY.

## Structure
- Shared header voice_scan_defs.vh: state encodings (3-bit), NUM_CHANNELS=16, CHANNEL_W=4.
- Sub-module next_channel_finder: combinational; inputs mask, start index, inclusive flag; outputs 4-bit next index, found, wrapped. Implemented as rotate plus priority encode.
- Top holds the FSM, settle counter, frame/restart flags, and output registers.

## Test plan
- Mask 16'hFFFF, ready high, SETTLE=4: loads on channels 0..15 in order, 7 cycles apart; o_frame_start on channel 0 only; second pass repeats.
- Mask 16'h8421: select sequence 0,5,10,15,0; o_frame_start with loads on channel 0; 28-cycle frame.
- Mask 16'h0010: every load is channel 4 with o_frame_start high; period 7 cycles.
- Ready low for 10 cycles in WAIT_READY on channel 3: o_select holds at 3; load fires exactly once, one cycle after ready returns high.
- Clear mask bit 6 while settling on channel 6 (mask 16'h00C0): no load for 6; next load is channel 7. Then mask goes to 0: IDLE, o_busy low.
- i_enable low mid-SETTLE: current load completes, then IDLE. Reset pulse mid-WAIT_READY: all outputs 0 next cycle; on re-enable the scan starts at the lowest enabled channel with o_frame_start.

Source files
------------

// File: rtl/voice_mux_scanner_pkg.sv
// ---------------------------------------------------------------------------
// voice_mux_scanner_pkg
//   Shared definitions for the voice mux scanner: channel count, select
//   width, FSM state encoding and a small mask helper.
// ---------------------------------------------------------------------------
package voice_mux_scanner_pkg;

    localparam int NUM_CHANNELS = 16;
    localparam int CHANNEL_W    = 4;
    localparam int SETTLE_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEEK       = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_LOAD       = 3'd4
    } scan_state_t;

    // True when the given channel is still part of the scan.
    function automatic logic channel_enabled(
        input logic [NUM_CHANNELS-1:0] mask,
        input logic [CHANNEL_W-1:0]    idx
    );
        return mask[idx];
    endfunction

endpackage

// File: rtl/voice_mux_scanner_next_channel_finder.sv
// ---------------------------------------------------------------------------
// voice_mux_scanner_next_channel_finder
//   Combinational search for the next enabled channel in ascending order
//   with wrap-around. The mask is rotated so the first candidate sits at
//   bit 0, then the lowest set bit is priority-encoded.
//
//   mask       in  16  enabled channels
//   start_idx  in  4   reference channel for the search
//   inclusive  in  1   1: start_idx is the first candidate
//                      0: start_idx+1 is first, start_idx is examined last
//   next_idx   out 4   channel found
//   found      out 1   at least one channel enabled
//   wrapped    out 1   search passed channel 15 back to the start side
// ---------------------------------------------------------------------------
module voice_mux_scanner_next_channel_finder
    import voice_mux_scanner_pkg::*;
(
    input  logic [NUM_CHANNELS-1:0] mask,
    input  logic [CHANNEL_W-1:0]    start_idx,
    input  logic                    inclusive,
    output logic [CHANNEL_W-1:0]    next_idx,
    output logic                    found,
    output logic                    wrapped
);

    logic [CHANNEL_W-1:0]    first_idx;
    logic [NUM_CHANNELS-1:0] rotated;
    logic [CHANNEL_W-1:0]    offset;

    // 4-bit addition wraps 15 -> 0 for free.
    assign first_idx = inclusive ? start_idx : start_idx + 1'b1;

    // Rotate right so bit 0 of 'rotated' is channel first_idx.
    assign rotated = (mask >> first_idx) | (mask << (NUM_CHANNELS - int'(first_idx)));

    // NOTE: every variable driven in always_comb gets a default before any
    // branch; a path that leaves it unassigned would infer a latch.
    always_comb begin
        offset = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i[CHANNEL_W-1:0];
            end
        end
    end

    assign next_idx = first_idx + offset;
    assign found    = |mask;
    // An exclusive search that lands on or below its start has gone round.
    assign wrapped  = inclusive ? (next_idx < start_idx) : (next_idx <= start_idx);

endmodule

// File: rtl/voice_mux_scanner.sv
// ---------------------------------------------------------------------------
// voice_mux_scanner
//   Drives the select of the 16-to-1 voice mux and paces samples into the
//   shared DAC. Enabled channels are visited in ascending order with
//   wrap-around; after each select change the mux is given SETTLE_CYCLES to
//   settle, then the DAC handshake is awaited and a one-cycle load issued.
//
//   SETTLE_CYCLES    param    settle time after a select change (1..255)
//   i_clock          in  1    system clock, rising edge
//   i_reset          in  1    synchronous active-high reset
//   i_enable         in  1    run scanning; low stops after current load
//   i_channel_mask   in  16   bit n = channel n included in the scan
//   i_dac_ready      in  1    DAC can accept a sample this cycle
//   o_select         out 4    mux select
//   o_dac_load       out 1    one-cycle DAC capture strobe
//   o_frame_start    out 1    with o_dac_load on first channel of a pass
//   o_busy           out 1    high in every state except IDLE
// ---------------------------------------------------------------------------
module voice_mux_scanner
    import voice_mux_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [NUM_CHANNELS-1:0] i_channel_mask,
    input  logic                    i_dac_ready,
    output logic [CHANNEL_W-1:0]    o_select,
    output logic                    o_dac_load,
    output logic                    o_frame_start,
    output logic                    o_busy
);

    localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    scan_state_t          state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [CHANNEL_W-1:0] select_d;
    logic                 frame_q, frame_d;
    logic                 restart_q, restart_d;
    logic                 load_d, frame_start_d, busy_d;

    logic                 mask_any;
    logic                 cur_enabled;
    logic [CHANNEL_W-1:0] find_idx;
    logic                 find_found;
    logic                 find_wrapped;

    assign mask_any    = |i_channel_mask;
    assign cur_enabled = channel_enabled(i_channel_mask, o_select);

    // After a restart the search begins at channel 0 inclusive; otherwise it
    // begins just past the current channel.
    voice_mux_scanner_next_channel_finder u_finder (
        .mask      (i_channel_mask),
        .start_idx (restart_q ? '0 : o_select),
        .inclusive (restart_q),
        .next_idx  (find_idx),
        .found     (find_found),
        .wrapped   (find_wrapped)
    );

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        select_d      = o_select;
        frame_d       = frame_q;
        restart_d     = restart_q;
        load_d        = 1'b0;
        frame_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && mask_any) begin
                    state_d = ST_SEEK;
                end
            end

            ST_SEEK: begin
                if (!find_found) begin
                    state_d   = ST_IDLE;
                    restart_d = 1'b1;
                end else begin
                    select_d  = find_idx;
                    frame_d   = frame_q | restart_q | find_wrapped;
                    restart_d = 1'b0;
                    settle_d  = SETTLE_RELOAD;
                    state_d   = ST_SETTLE;
                end
            end

            ST_SETTLE, ST_WAIT_READY: begin
                // Losing the current channel abandons this sample; the frame
                // flag is kept so a pass that began here still reports it.
                if (!mask_any) begin
                    state_d   = ST_IDLE;
                    restart_d = 1'b1;
                end else if (!cur_enabled) begin
                    state_d = ST_SEEK;
                end else if (state_q == ST_SETTLE) begin
                    if (settle_q == '0) begin
                        state_d = ST_WAIT_READY;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end else if (i_dac_ready) begin
                    state_d       = ST_LOAD;
                    load_d        = 1'b1;
                    frame_start_d = frame_q;
                end
            end

            ST_LOAD: begin
                frame_d = 1'b0;
                if (i_enable && mask_any) begin
                    state_d = ST_SEEK;
                end else begin
                    state_d   = ST_IDLE;
                    restart_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                restart_d = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge i_clock) begin
        // NOTE: reset is synchronous; it is only seen on a rising edge.
        if (i_reset) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            o_select      <= '0;
            frame_q       <= 1'b0;
            restart_q     <= 1'b1;
            o_dac_load    <= 1'b0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            o_select      <= select_d;
            frame_q       <= frame_d;
            restart_q     <= restart_d;
            o_dac_load    <= load_d;
            o_frame_start <= frame_start_d;
            o_busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_voice_mux_scanner.sv
// ---------------------------------------------------------------------------
// tb_voice_mux_scanner
//   Self-checking bench for voice_mux_scanner. A slot-position reference
//   model predicts every output each cycle; directed scenarios additionally
//   check the observed load log against hand-derived sequences.
// ---------------------------------------------------------------------------
module tb_voice_mux_scanner;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] i_channel_mask;
    logic        i_dac_ready;
    logic [3:0]  o_select;
    logic        o_dac_load;
    logic        o_frame_start;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit model_valid = 0;

    // Observed loads.
    int ld_ch[$];
    int ld_cyc[$];
    int ld_fs[$];

    // Reference model: position within a channel slot.
    // -1 idle, 0 seek, 1..S settle, S+1 waiting for DAC, S+2 load.
    int m_pos = -1;
    int m_sel = 0;
    bit m_restart = 1;
    bit m_frame = 0;
    bit m_load = 0;
    bit m_fs = 0;
    bit m_busy = 0;

    always #5 clk = ~clk;

    voice_mux_scanner #(.SETTLE_CYCLES(S)) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_channel_mask (i_channel_mask),
        .i_dac_ready    (i_dac_ready),
        .o_select       (o_select),
        .o_dac_load     (o_dac_load),
        .o_frame_start  (o_frame_start),
        .o_busy         (o_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int next_enabled(input logic [15:0] mask, input int sel, input bit from_zero);
        if (from_zero) begin
            for (int k = 0; k < 16; k++) if (mask[k]) return k;
        end else begin
            for (int k = 1; k <= 16; k++) if (mask[(sel + k) % 16]) return (sel + k) % 16;
        end
        return sel;
    endfunction

    task automatic model_go_idle();
        m_pos     = -1;
        m_restart = 1;
    endtask

    always @(posedge clk) begin
        int c;
        cyc++;
        if (i_reset) begin
            m_pos = -1; m_sel = 0; m_restart = 1; m_frame = 0;
        end else if (m_pos == -1) begin
            if (i_enable && i_channel_mask != 0) m_pos = 0;
        end else if (m_pos == 0) begin
            if (i_channel_mask == 0) begin
                model_go_idle();
            end else begin
                c = next_enabled(i_channel_mask, m_sel, m_restart);
                if (m_restart || c <= m_sel) m_frame = 1;
                m_restart = 0;
                m_sel = c;
                m_pos = 1;
            end
        end else if (m_pos <= S + 1) begin
            if (i_channel_mask == 0)             model_go_idle();
            else if (!i_channel_mask[m_sel])     m_pos = 0;
            else if (m_pos <= S || i_dac_ready)  m_pos++;
        end else begin
            m_frame = 0;
            if (i_enable && i_channel_mask != 0) m_pos = 0;
            else                                 model_go_idle();
        end
        m_load = (m_pos == S + 2);
        m_fs   = m_load && m_frame;
        m_busy = (m_pos != -1);
        model_valid = 1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("select",      o_select,      m_sel[3:0]);
            check("dac_load",    o_dac_load,    m_load);
            check("frame_start", o_frame_start, m_fs);
            check("busy",        o_busy,        m_busy);
            if (o_dac_load === 1'b1) begin
                ld_ch.push_back(int'(o_select));
                ld_cyc.push_back(cyc);
                ld_fs.push_back(int'(o_frame_start));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        ld_ch.delete();
        ld_cyc.delete();
        ld_fs.delete();
    endtask

    task automatic wait_loads(input int n, input int budget, input string name);
        int c = 0;
        while (ld_ch.size() < n && c < budget) begin
            tick();
            c++;
        end
        check({name, "_load_count"}, (ld_ch.size() >= n), 1);
    endtask

    task automatic stop_scan(input string name);
        int c = 0;
        i_enable = 0;
        while (o_busy && c < 100) begin
            tick();
            c++;
        end
        check({name, "_idle"}, o_busy, 0);
    endtask

    initial begin
        i_reset = 1; i_enable = 0; i_channel_mask = 0; i_dac_ready = 0;
        repeat (3) tick();
        check("reset_select", o_select, 0);
        check("reset_load",   o_dac_load, 0);
        check("reset_frame",  o_frame_start, 0);
        check("reset_busy",   o_busy, 0);
        i_reset = 0;
        tick();

        // Full mask: two passes, channel order, 7-cycle spacing.
        clear_log();
        i_channel_mask = 16'hFFFF; i_dac_ready = 1; i_enable = 1;
        wait_loads(32, 300, "full");
        for (int i = 0; i < 32 && i < ld_ch.size(); i++) begin
            check("full_ch", ld_ch[i], i % 16);
            check("full_fs", ld_fs[i], (i % 16 == 0) ? 1 : 0);
            if (i > 0) check("full_period", ld_cyc[i] - ld_cyc[i-1], S + 3);
        end
        stop_scan("full");

        // Sparse mask 8421.
        clear_log();
        i_channel_mask = 16'h8421; i_enable = 1;
        wait_loads(5, 100, "sparse");
        if (ld_ch.size() >= 5) begin
            check("sparse_ch0", ld_ch[0], 0);
            check("sparse_ch1", ld_ch[1], 5);
            check("sparse_ch2", ld_ch[2], 10);
            check("sparse_ch3", ld_ch[3], 15);
            check("sparse_ch4", ld_ch[4], 0);
            check("sparse_fs0", ld_fs[0], 1);
            check("sparse_fs1", ld_fs[1], 0);
            check("sparse_fs3", ld_fs[3], 0);
            check("sparse_fs4", ld_fs[4], 1);
            check("sparse_frame", ld_cyc[4] - ld_cyc[0], 28);
        end
        stop_scan("sparse");

        // Single channel: every load is a frame start.
        clear_log();
        i_channel_mask = 16'h0010; i_enable = 1;
        wait_loads(3, 60, "single");
        for (int i = 0; i < 3 && i < ld_ch.size(); i++) begin
            check("single_ch", ld_ch[i], 4);
            check("single_fs", ld_fs[i], 1);
            if (i > 0) check("single_period", ld_cyc[i] - ld_cyc[i-1], 7);
        end
        stop_scan("single");

        // DAC not ready while waiting on channel 3.
        clear_log();
        i_channel_mask = 16'hFFFF; i_enable = 1; i_dac_ready = 1;
        wait_loads(3, 60, "ready");
        i_dac_ready = 0;
        repeat (16) tick();
        check("ready_hold_sel",   o_select, 3);
        check("ready_hold_count", ld_ch.size(), 3);
        check("ready_hold_busy",  o_busy, 1);
        i_dac_ready = 1;
        tick();
        check("ready_load",     o_dac_load, 1);
        check("ready_load_sel", o_select, 3);
        tick();
        check("ready_once", ld_ch.size(), 4);
        stop_scan("ready");

        // Abort: channel 6 dropped mid-settle, then whole mask cleared.
        clear_log();
        i_channel_mask = 16'h00C0; i_enable = 1;
        tick();
        tick();
        check("abort_sel6", o_select, 6);
        tick();
        i_channel_mask = 16'h0080;
        wait_loads(1, 30, "abort");
        if (ld_ch.size() >= 1) begin
            check("abort_ch", ld_ch[0], 7);
            check("abort_fs", ld_fs[0], 1);
        end
        tick();
        tick();
        i_channel_mask = 16'h0000;
        tick();
        check("abort_idle",  o_busy, 0);
        check("abort_count", ld_ch.size(), 1);
        i_enable = 0;
        tick();

        // Enable dropped mid-settle: the sample still completes.
        clear_log();
        i_channel_mask = 16'hFFFF; i_enable = 1;
        repeat (3) tick();
        i_enable = 0;
        begin
            int c = 0;
            while ((o_busy || c < 2) && c < 30) begin
                tick();
                c++;
            end
        end
        check("enlow_count", ld_ch.size(), 1);
        if (ld_ch.size() >= 1) begin
            check("enlow_ch", ld_ch[0], 0);
            check("enlow_fs", ld_fs[0], 1);
        end
        check("enlow_idle", o_busy, 0);

        // Reset while waiting; restart from lowest enabled channel.
        clear_log();
        i_channel_mask = 16'h00F0; i_dac_ready = 1; i_enable = 1;
        wait_loads(2, 40, "rst");
        i_dac_ready = 0;
        repeat (10) tick();
        check("rst_wait_sel", o_select, 6);
        i_reset = 1;
        tick();
        check("rst_sel",   o_select, 0);
        check("rst_load",  o_dac_load, 0);
        check("rst_frame", o_frame_start, 0);
        check("rst_busy",  o_busy, 0);
        i_reset = 0; i_dac_ready = 1;
        wait_loads(3, 40, "rst_resume");
        if (ld_ch.size() >= 3) begin
            check("rst_resume_ch", ld_ch[2], 4);
            check("rst_resume_fs", ld_fs[2], 1);
        end

        // Randomized traffic, checked each cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if ($urandom_range(39) == 0) begin
                case ($urandom_range(3))
                    0: i_channel_mask = 16'($urandom);
                    1: i_channel_mask = 16'(1) << $urandom_range(15);
                    2: i_channel_mask = 16'h0000;
                    default: i_channel_mask = 16'hFFFF;
                endcase
            end
            if ($urandom_range(15) == 0) i_channel_mask[$urandom_range(15)] ^= 1'b1;
            i_dac_ready = ($urandom_range(3) != 0);
            if (i_enable) begin
                if ($urandom_range(99) == 0) i_enable = 0;
            end else if ($urandom_range(19) == 0) begin
                i_enable = 1;
            end
            i_reset = ($urandom_range(399) == 0);
        end
        i_reset = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
